// File: rtl/conv_seq_pkg.sv
// Shared types and default layer dimensions for the conv2d layer sequencer.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_WAIT_W = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  localparam int unsigned DEF_IMG_W    = 224;
  localparam int unsigned DEF_IMG_H    = 224;
  localparam int unsigned DEF_CH_IN    = 64;
  localparam int unsigned DEF_CH_OUT   = 64;
  localparam int unsigned DEF_PIPE_LAT = 5;
  localparam int unsigned DEF_DIM_W    = 8;
  localparam int unsigned DEF_CH_W     = 10;

  // Drain counter must hold values 0..lat
  function automatic int unsigned drain_cnt_w(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/seq_wrap_counter.sv
// Index counter that wraps from MAX to 0; last_c flags the wrap point for carry chaining.
module seq_wrap_counter #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last_c
);

  assign last_c = (count == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= last_c ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv2d_layer_sequencer.sv
// Walks cout/cin/row/col loops of one conv layer, issuing weight loads, pixel windows and pipeline drains.
// Optional stall-cycle performance counter enabled by defining SEQ_PERF_CNT_EN.
module conv2d_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned IMG_W    = DEF_IMG_W,
  parameter int unsigned IMG_H    = DEF_IMG_H,
  parameter int unsigned CH_IN    = DEF_CH_IN,
  parameter int unsigned CH_OUT   = DEF_CH_OUT,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
  parameter int unsigned DIM_W    = DEF_DIM_W,
  parameter int unsigned CH_W     = DEF_CH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             weights_ready,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             load_weights,
  output logic             pix_valid,
  output logic [DIM_W-1:0] win_row,
  output logic [DIM_W-1:0] win_col,
  output logic [CH_W-1:0]  ch_in_idx,
  output logic [CH_W-1:0]  ch_out_idx,
  output logic             first_cin,
  output logic             last_cin,
  output logic [31:0]      stall_cycles
);

  localparam int unsigned DRAIN_W = drain_cnt_w(PIPE_LAT);

  seq_state_t         state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic pix_valid_d, load_weights_d, done_d, busy_d, first_cin_d, last_cin_d;
  logic clear_idx, col_en, row_en, cin_en, cout_en;
  logic col_last, row_last, cin_last, cout_last;

  // Index counters always point at the window shown on the outputs
  seq_wrap_counter #(.W(DIM_W), .MAX(IMG_W - 1)) u_col (
    .clk(clk), .rst(rst), .clear(clear_idx), .en(col_en), .count(win_col), .last_c(col_last)
  );
  seq_wrap_counter #(.W(DIM_W), .MAX(IMG_H - 1)) u_row (
    .clk(clk), .rst(rst), .clear(clear_idx), .en(row_en), .count(win_row), .last_c(row_last)
  );
  seq_wrap_counter #(.W(CH_W), .MAX(CH_IN - 1)) u_cin (
    .clk(clk), .rst(rst), .clear(clear_idx), .en(cin_en), .count(ch_in_idx), .last_c(cin_last)
  );
  seq_wrap_counter #(.W(CH_W), .MAX(CH_OUT - 1)) u_cout (
    .clk(clk), .rst(rst), .clear(clear_idx), .en(cout_en), .count(ch_out_idx), .last_c(cout_last)
  );

  assign row_en  = col_en && col_last;
  assign cout_en = cin_en && cin_last;

  // Next state plus the values every registered output takes in the next cycle
  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    pix_valid_d    = 1'b0;
    load_weights_d = 1'b0;
    done_d         = 1'b0;
    clear_idx      = 1'b0;
    col_en         = 1'b0;
    cin_en         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_LOAD_W;
          load_weights_d = 1'b1;
          clear_idx      = 1'b1;
        end
      end
      ST_LOAD_W: begin
        state_d = ST_WAIT_W;
      end
      ST_WAIT_W: begin
        if (weights_ready) begin
          state_d     = ST_STREAM;
          pix_valid_d = !stall;
        end
      end
      ST_STREAM: begin
        // A window shown with pix_valid is consumed at this edge
        col_en = pix_valid;
        if (pix_valid && col_last && row_last) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(PIPE_LAT);
        end else begin
          pix_valid_d = !stall;
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          if (drain_q == DRAIN_W'(1)) begin
            cin_en = 1'b1;
            if (cin_last && cout_last) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d        = ST_LOAD_W;
              load_weights_d = 1'b1;
            end
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        clear_idx = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    first_cin_d = pix_valid_d && (ch_in_idx == '0);
    last_cin_d  = pix_valid_d && (ch_in_idx == CH_W'(CH_IN - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      drain_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_weights <= 1'b0;
      pix_valid    <= 1'b0;
      first_cin    <= 1'b0;
      last_cin     <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      busy         <= busy_d;
      done         <= done_d;
      load_weights <= load_weights_d;
      pix_valid    <= pix_valid_d;
      first_cin    <= first_cin_d;
      last_cin     <= last_cin_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Saturating count of backpressured busy cycles, restarted per layer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state_q == ST_IDLE && start) begin
      stall_cycles <= '0;
    end else if (busy && stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
